clock_tick_scheduler: RTL and testbench
=======================================

Name: clock_tick_scheduler

Overview:
- Schedules periodic events for up to CHANNELS requesters from one shared prescaled time base.
- The prescaler divides clk_in by FREQ_IN/FREQ_TICK, and each channel counts base ticks against a programmable period.
- Expired channels raise pending events, and a round-robin arbiter serialises them onto one valid/ready event port.
- The block sits beside the clock divider and gives the design software-configurable timers without one divider per consumer.

Parameters:
BUS_WIDTH, 32, width of period registers and channel counters
FREQ_IN, 1000000, input clock frequency in Hz
FREQ_TICK, 1000, base tick frequency in Hz; PRESCALE = FREQ_IN / FREQ_TICK (integer division, must be >= 1)
CHANNELS, 4, number of timer channels (2..16)
CHAN_W, 2, width of the channel index; CHANNELS <= 2**CHAN_W

Ports:
clk_in  input  1  single system clock; all logic is on its rising edge
rst  input  1  synchronous reset, active-high
cfg_we  input  1  one-cycle write strobe; always accepted
cfg_chan  input  CHAN_W  channel addressed by the write
cfg_period  input  BUS_WIDTH  new period in base ticks; 0 disables the channel
ovr_clr  input  CHANNELS  per-channel overrun clear, sampled every cycle
base_tick  output  1  one-cycle pulse each PRESCALE cycles
evt_valid  output  1  event available
evt_chan  output  CHAN_W  channel of the offered event
evt_ready  input  1  consumer accepts the event
overrun  output  CHANNELS  sticky per-channel overrun flags

Behaviour:
- Reset, rst high at an edge:
  - Prescale counter, all periods, channel counters, pending bits, overrun and the RR pointer are cleared to 0.
  - base_tick=0, evt_valid=0, evt_chan=0.
  - Reset mid-handshake drops the offered event without an acceptance.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and wraps.
  - base_tick is registered high for the cycle after pcnt==PRESCALE-1. With PRESCALE=1, base_tick is constantly 1 after the first post-reset cycle.
- Channel expiry:
  - A channel is active when its period P != 0.
  - On each base_tick, an active channel increments its counter. When counter==P-1 the counter wraps to 0 and an expiry occurs.
  - An inactive channel's counter holds at 0.
- Expiry effects:
  - If pending[ch]==0, expiry sets pending[ch]=1.
  - If pending[ch]==1 and it is not being accepted this cycle, expiry sets overrun[ch]=1 and pending stays 1. Events are not queued.
- Config write:
  - cfg_we loads period[cfg_chan] and clears counter, pending and overrun for that channel.
  - A write takes priority over a same-cycle expiry of that channel.
  - cfg_chan >= CHANNELS is ignored.
  - A write to the channel currently offered on evt_* does not retract the offer. If accepted, the handshake completes normally and pending stays cleared.
- Arbitration:
  - When evt_valid==0, the grant is the first channel with pending=1 searching from ptr upward and wrapping.
  - If one is found, evt_valid=1 and evt_chan=grant at the next edge.
  - evt_chan is held stable while evt_valid=1 && evt_ready=0.
- Handshake (evt_valid && evt_ready at an edge):
  - pending[evt_chan] is cleared, evt_valid goes to 0, and ptr = (evt_chan+1) mod CHANNELS.
  - The next grant can appear one edge later, so the peak rate is one event per 2 cycles.
- Simultaneous events:
  - Expiry of the accepted channel in its handshake cycle leaves pending=1 with no overrun.
  - ovr_clr and a same-cycle overrun set resolve to set.
- Latency:
  - Expiry at edge k gives pending at k and evt_valid at k+1, when the port is idle.
  - Overrun flags update at the same edge as the expiry.

Test Plan:
- FREQ_IN=1000, FREQ_TICK=100, reset held 3 cycles -> all outputs 0; base_tick pulses every 10 cycles, first pulse 10 cycles after reset release.
- Write ch1 period=3, evt_ready tied 1 -> evt_valid/evt_chan=1 once every 30 cycles, 1 cycle after each third base_tick; overrun=0.
- ch0..ch3 period=2 written in the same tick window, evt_ready=1 -> events in order 0,1,2,3 on alternating cycles; ptr wrap verified by the next round starting at 0.
- ch2 period=1, evt_ready=0 for 25 cycles -> evt_chan stays 2 throughout; overrun[2]=1 after the second base_tick; pulse ovr_clr[2] -> overrun[2]=0 next cycle.
- ch0 period=5, then write period=0 mid-count -> no further events; rewrite period=2 -> first event after exactly 2 base_ticks.
- Assert rst while evt_valid=1 -> next cycle evt_valid=0, overrun=0; no event until channels are reprogrammed.

Source files
------------

// File: rtl/clock_tick_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// clock_tick_scheduler: one prescaled base tick drives CHANNELS periodic timers;
// expiries become pending events served round-robin on a valid/ready port.
module clock_tick_scheduler #(
  parameter int BUS_WIDTH = 32,
  parameter int FREQ_IN   = 1000000,
  parameter int FREQ_TICK = 1000,
  parameter int CHANNELS  = 4,
  parameter int CHAN_W    = 2
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [CHAN_W-1:0]    cfg_chan,
  input  logic [BUS_WIDTH-1:0] cfg_period,
  input  logic [CHANNELS-1:0]  ovr_clr,
  output logic                 base_tick,
  output logic                 evt_valid,
  output logic [CHAN_W-1:0]    evt_chan,
  input  logic                 evt_ready,
  output logic [CHANNELS-1:0]  overrun
);

  localparam int PRESCALE = FREQ_IN / FREQ_TICK;
  localparam int PCNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0]   pcnt;
  logic [CHANNELS-1:0] pending;
  logic [CHAN_W-1:0]   ptr;
  logic [CHAN_W-1:0]   grant;
  logic                found;
  logic                accept;

  assign accept = evt_valid && evt_ready;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      pcnt      <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= (pcnt == PCNT_MAX);
      pcnt      <= (pcnt == PCNT_MAX) ? '0 : pcnt + PCNT_W'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [BUS_WIDTH-1:0] period;
    logic [BUS_WIDTH-1:0] count;
    logic                 pend;
    logic                 ovr;
    logic                 active;
    logic                 expire;
    logic                 wr_sel;
    logic                 acc_sel;

    assign active  = (period != '0);
    assign expire  = base_tick && active && (count == period - BUS_WIDTH'(1));
    assign wr_sel  = cfg_we && (cfg_chan == CHAN_W'(g));
    assign acc_sel = accept && (evt_chan == CHAN_W'(g));

    assign pending[g] = pend;
    assign overrun[g] = ovr;

    // A config write wins over everything else happening to this channel.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        period <= '0;
        count  <= '0;
        pend   <= 1'b0;
        ovr    <= 1'b0;
      end else if (wr_sel) begin
        period <= cfg_period;
        count  <= '0;
        pend   <= 1'b0;
        ovr    <= 1'b0;
      end else begin
        if (base_tick && active)
          count <= expire ? '0 : count + BUS_WIDTH'(1);
        if (expire) begin
          pend <= 1'b1;
          if (pend && !acc_sel)
            ovr <= 1'b1;
          else if (ovr_clr[g])
            ovr <= 1'b0;
        end else begin
          if (acc_sel)
            pend <= 1'b0;
          if (ovr_clr[g])
            ovr <= 1'b0;
        end
      end
    end
  end

  // First pending channel at or above ptr, wrapping round.
  always_comb begin
    int idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(ptr) + i;
      if (idx >= CHANNELS)
        idx = idx - CHANNELS;
      if (!found && pending[idx]) begin
        found = 1'b1;
        grant = CHAN_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_chan  <= '0;
      ptr       <= '0;
    end else if (evt_valid) begin
      if (evt_ready) begin
        evt_valid <= 1'b0;
        ptr       <= (evt_chan == CHAN_W'(CHANNELS - 1)) ? '0 : evt_chan + CHAN_W'(1);
      end
    end else if (found) begin
      evt_valid <= 1'b1;
      evt_chan  <= grant;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_tick_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// tb_clock_tick_scheduler: scoreboard bench with PRESCALE=10; expected events
// (channel, cycle) are queued as stimulus is driven and popped on each handshake.
module tb_clock_tick_scheduler;

  localparam int BUS_WIDTH = 32;
  localparam int CHANNELS  = 4;
  localparam int CHAN_W    = 2;
  localparam int PRESCALE  = 10;

  logic                 clk_in = 1'b0;
  logic                 rst = 1'b1;
  logic                 cfg_we = 1'b0;
  logic [CHAN_W-1:0]    cfg_chan = '0;
  logic [BUS_WIDTH-1:0] cfg_period = '0;
  logic [CHANNELS-1:0]  ovr_clr = '0;
  logic                 base_tick;
  logic                 evt_valid;
  logic [CHAN_W-1:0]    evt_chan;
  logic                 evt_ready = 1'b0;
  logic [CHANNELS-1:0]  overrun;

  clock_tick_scheduler #(
    .BUS_WIDTH (BUS_WIDTH),
    .FREQ_IN   (1000),
    .FREQ_TICK (100),
    .CHANNELS  (CHANNELS),
    .CHAN_W    (CHAN_W)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_chan   (cfg_chan),
    .cfg_period (cfg_period),
    .ovr_clr    (ovr_clr),
    .base_tick  (base_tick),
    .evt_valid  (evt_valid),
    .evt_chan   (evt_chan),
    .evt_ready  (evt_ready),
    .overrun    (overrun)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int chan;
    int cyc;
  } evt_t;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   bt_en    = 1'b0;
  bit   mon_en   = 1'b0;

  // cyc = rising edges since reset was last released
  always @(posedge clk_in) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d (cyc=%0d t=%0t)", tag, got, want, cyc, $time);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic cfg_write(input int ch, input int p);
    cfg_we     = 1'b1;
    cfg_chan   = CHAN_W'(ch);
    cfg_period = BUS_WIDTH'(p);
    @(posedge clk_in);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic push(input int ch, input int c);
    evt_t e;
    e.chan = ch;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  always @(negedge clk_in)
    if (bt_en)
      chk("base_tick", 64'(base_tick), 64'((cyc % PRESCALE == 0) && (cyc != 0)));

  always @(negedge clk_in) begin
    if (mon_en && evt_valid === 1'b1 && evt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", 64'(evt_valid), 64'(0));
      end else begin
        evt_t e;
        e = exp_q.pop_front();
        chk("evt_chan", 64'(evt_chan), 64'(e.chan));
        chk("evt_cyc", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    // Reset held for three edges
    repeat (3) begin
      @(posedge clk_in);
      #1;
      bt_en = 1'b1;
      @(negedge clk_in);
      chk("rst_valid", 64'(evt_valid), 64'(0));
      chk("rst_chan", 64'(evt_chan), 64'(0));
      chk("rst_ovr", 64'(overrun), 64'(0));
    end
    rst = 1'b0;
    @(posedge clk_in);
    #1;
    mon_en    = 1'b1;
    evt_ready = 1'b1;

    // All four channels period 2: two full rounds in index order
    wait_cyc(112);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CHANNELS; c++)
        push(c, 132 + 20 * r + 2 * c);
    for (int c = 0; c < CHANNELS; c++) cfg_write(c, 2);
    wait_cyc(160);
    for (int c = 0; c < CHANNELS; c++) cfg_write(c, 0);
    chk("rr_q_empty", 64'(exp_q.size()), 64'(0));

    // ch1 period 3: one event every third base tick
    wait_cyc(165);
    push(1, 192);
    push(1, 222);
    push(1, 252);
    cfg_write(1, 3);
    wait_cyc(258);
    @(negedge clk_in);
    chk("p3_ovr", 64'(overrun), 64'(0));
    chk("p3_q_empty", 64'(exp_q.size()), 64'(0));
    wait_cyc(260);
    cfg_write(1, 0);

    // ch2 period 1 with consumer stalled: stable offer, overrun, clear
    wait_cyc(262);
    evt_ready = 1'b0;
    push(2, 296);
    cfg_write(2, 1);
    wait_cyc(272);
    while (cyc < 296) begin
      @(negedge clk_in);
      chk("stall_valid", 64'(evt_valid), 64'(1));
      chk("stall_chan", 64'(evt_chan), 64'(2));
      if (cyc == 280) chk("ovr_before", 64'(overrun), 64'(0));
      if (cyc == 281) chk("ovr_set", 64'(overrun), 64'(4'b0100));
      if (cyc == 286) chk("ovr_clr", 64'(overrun), 64'(0));
      if (cyc == 291) chk("ovr_set_wins", 64'(overrun), 64'(4'b0100));
      @(posedge clk_in);
      #1;
      ovr_clr = (cyc == 285 || cyc == 290) ? 4'b0100 : 4'b0000;
    end
    evt_ready = 1'b1;
    wait_cyc(297);
    cfg_write(2, 0);
    @(negedge clk_in);
    chk("wr_clears_ovr", 64'(overrun), 64'(0));

    // ch0 period 5, disabled mid-count, then period 2
    wait_cyc(305);
    push(0, 392);
    cfg_write(0, 5);
    wait_cyc(325);
    cfg_write(0, 0);
    wait_cyc(372);
    cfg_write(0, 2);
    wait_cyc(393);
    cfg_write(0, 0);
    chk("dis_q_empty", 64'(exp_q.size()), 64'(0));

    // Reset while an event is offered
    wait_cyc(396);
    evt_ready = 1'b0;
    cfg_write(3, 1);
    wait_cyc(402);
    @(negedge clk_in);
    chk("pre_rst_valid", 64'(evt_valid), 64'(1));
    chk("pre_rst_chan", 64'(evt_chan), 64'(3));
    wait_cyc(411);
    @(negedge clk_in);
    chk("pre_rst_ovr", 64'(overrun), 64'(4'b1000));
    wait_cyc(412);
    rst = 1'b1;
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    @(negedge clk_in);
    chk("mid_rst_valid", 64'(evt_valid), 64'(0));
    chk("mid_rst_ovr", 64'(overrun), 64'(0));
    chk("mid_rst_chan", 64'(evt_chan), 64'(0));
    evt_ready = 1'b1;
    wait_cyc(60);
    chk("final_q_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
